// File: rtl/mdom_scdb_hdr_builder.sv
// mdom_scdb_hdr_builder
// Builds the 111-bit scdb header bundle for one waveform-buffer channel.
// Open-time metadata (ltc, start address, trigger info) is latched on
// trig_start; the stop address and baseline-sum fields are taken on close.
// Records longer than MAX_SAMPLES are split into a partial record followed
// by continuation records. Closed headers enter a 2-entry valid/ready queue.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   trig_start, trig_end     record open / close pulses
//   ltc, wr_addr             time counter and buffer write address
//   *_in                     header metadata inputs
//   hdr_bundle, hdr_valid    queue head (registered)
//   hdr_ready                consumer accept
//   busy                     record open
//   drop_cnt                 saturating count of headers lost to a full queue
module mdom_scdb_hdr_builder #(
   parameter int unsigned MAX_SAMPLES = 256
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          trig_start,
   input  logic          trig_end,
   input  logic [48:0]   ltc,
   input  logic [10:0]   wr_addr,
   input  logic [1:0]    trig_src_in,
   input  logic          cnst_run_in,
   input  logic [4:0]    pre_conf_in,
   input  logic          sync_rdy_in,
   input  logic          local_coinc_in,
   input  logic [4:0]    channel_idx_in,
   input  logic [18:0]   bsum_in,
   input  logic [2:0]    bsum_len_sel_in,
   input  logic          bsum_valid_in,
   output logic [110:0]  hdr_bundle,
   output logic          hdr_valid,
   input  logic          hdr_ready,
   output logic          busy,
   output logic [15:0]   drop_cnt
);

   localparam int unsigned HDR_W  = 111;
   localparam int unsigned LTC_W  = 49;
   localparam int unsigned ADDR_W = 11;
   localparam int unsigned CNT_W  = 12;
   localparam int unsigned DROP_W = 16;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_OPEN = 1'b1;

   // cnt_q counts samples already taken before the current cycle, so the
   // current cycle is the last sample of a record when cnt_q == MAX_SAMPLES-1.
   localparam logic [CNT_W-1:0]  SPLIT_AT = CNT_W'(MAX_SAMPLES - 1);
   localparam logic [LTC_W-1:0]  LTC_STEP = LTC_W'(MAX_SAMPLES);
   localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

   logic [0:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [LTC_W-1:0]  ltc_q, ltc_d;
   logic [ADDR_W-1:0] start_q, start_d;
   logic [1:0]        trig_src_q, trig_src_d;
   logic              cnst_run_q, cnst_run_d;
   logic [4:0]        pre_conf_q, pre_conf_d;
   logic              sync_rdy_q, sync_rdy_d;
   logic              local_coinc_q, local_coinc_d;
   logic [4:0]        channel_idx_q, channel_idx_d;
   logic              cont_q, cont_d;

   logic [HDR_W-1:0]  q0_q, q0_d, q1_q, q1_d;
   logic              v0_q, v0_d, v1_q, v1_d;
   logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

   logic              close_c, partial_c, pop_c, push_c, drop_c;
   logic [HDR_W-1:0]  hdr_new_c;

   // Record FSM: open, count samples, close on trig_end or forced split.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      ltc_d         = ltc_q;
      start_d       = start_q;
      trig_src_d    = trig_src_q;
      cnst_run_d    = cnst_run_q;
      pre_conf_d    = pre_conf_q;
      sync_rdy_d    = sync_rdy_q;
      local_coinc_d = local_coinc_q;
      channel_idx_d = channel_idx_q;
      cont_d        = cont_q;
      close_c       = 1'b0;
      partial_c     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (trig_start) begin
               state_d       = ST_OPEN;
               ltc_d         = ltc;
               start_d       = wr_addr;
               trig_src_d    = trig_src_in;
               cnst_run_d    = cnst_run_in;
               pre_conf_d    = pre_conf_in;
               sync_rdy_d    = sync_rdy_in;
               local_coinc_d = local_coinc_in;
               channel_idx_d = channel_idx_in;
               cont_d        = 1'b0;
               cnt_d         = CNT_W'(1);
            end
         end
         ST_OPEN: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (trig_end) begin
               close_c = 1'b1;
               state_d = ST_IDLE;
            end else if (cnt_q == SPLIT_AT) begin
               // Continuation starts on the next sample; none taken yet.
               close_c   = 1'b1;
               partial_c = 1'b1;
               start_d   = wr_addr + ADDR_W'(1);
               ltc_d     = ltc_q + LTC_STEP;
               cont_d    = 1'b1;
               cnt_d     = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Header assembled from latched open-time fields plus close-time inputs.
   always_comb begin
      hdr_new_c = {channel_idx_q, cont_q, partial_c, local_coinc_q,
                   bsum_valid_in, bsum_len_sel_in, bsum_in, sync_rdy_q,
                   pre_conf_q, cnst_run_q, trig_src_q, wr_addr, start_q,
                   ltc_q};
   end

   // 2-entry output queue; q0 is the head. A pop frees a slot for a same-cycle push.
   always_comb begin
      q0_d       = q0_q;
      q1_d       = q1_q;
      v0_d       = v0_q;
      v1_d       = v1_q;
      drop_cnt_d = drop_cnt_q;
      pop_c      = v0_q & hdr_ready;
      push_c     = close_c & (~v1_q | pop_c);
      drop_c     = close_c & v1_q & ~pop_c;
      if (pop_c) begin
         q0_d = q1_q;
         v0_d = v1_q;
         v1_d = 1'b0;
      end
      if (push_c) begin
         if (!v0_d) begin
            q0_d = hdr_new_c;
            v0_d = 1'b1;
         end else begin
            q1_d = hdr_new_c;
            v1_d = 1'b1;
         end
      end
      if (drop_c && (drop_cnt_q != DROP_MAX)) begin
         drop_cnt_d = drop_cnt_q + DROP_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         ltc_q         <= '0;
         start_q       <= '0;
         trig_src_q    <= '0;
         cnst_run_q    <= 1'b0;
         pre_conf_q    <= '0;
         sync_rdy_q    <= 1'b0;
         local_coinc_q <= 1'b0;
         channel_idx_q <= '0;
         cont_q        <= 1'b0;
         q0_q          <= '0;
         q1_q          <= '0;
         v0_q          <= 1'b0;
         v1_q          <= 1'b0;
         drop_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         ltc_q         <= ltc_d;
         start_q       <= start_d;
         trig_src_q    <= trig_src_d;
         cnst_run_q    <= cnst_run_d;
         pre_conf_q    <= pre_conf_d;
         sync_rdy_q    <= sync_rdy_d;
         local_coinc_q <= local_coinc_d;
         channel_idx_q <= channel_idx_d;
         cont_q        <= cont_d;
         q0_q          <= q0_d;
         q1_q          <= q1_d;
         v0_q          <= v0_d;
         v1_q          <= v1_d;
         drop_cnt_q    <= drop_cnt_d;
      end
   end

   assign hdr_bundle = q0_q;
   assign hdr_valid  = v0_q;
   assign busy       = (state_q == ST_OPEN);
   assign drop_cnt   = drop_cnt_q;

endmodule
